// File: rtl/aidc_lite_comp_pingpong_buffer.sv
// Two-bank ping-pong staging buffer between the compressor packer and the output stage.
// One bank fills with byte-enabled writes while the other, once committed, is read and released.
module aidc_lite_comp_pingpong_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH/8-1:0] wbe_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wcommit_i,
    input  logic [ADDR_WIDTH:0]   wlen_i,
    output logic                  wready_o,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic [ADDR_WIDTH:0]   rlen_o,
    input  logic                  rrelease_i,
    output logic [1:0]            occ_o,
    output logic                  err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned LEN_W    = ADDR_WIDTH + 1;

    // Bank storage; never reset, visibility is gated by the full flags.
    logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];

    logic [1:0]       r_full;
    logic [LEN_W-1:0] r_len [2];
    logic             r_wbank;
    logic             r_rbank;
    logic             r_err;

    logic             w_len_ok;
    logic             w_wr_en;
    logic             w_commit;
    logic             w_bad_commit;
    logic             w_release;
    logic             w_rd_hit;
    logic [1:0]       w_full_nxt;
    logic             w_wbank_nxt;
    logic             w_rbank_nxt;

    // Status outputs derived directly from bank state.
    assign wready_o = ~r_full[r_wbank];
    assign rvalid_o = r_full[r_rbank];
    assign rlen_o   = rvalid_o ? r_len[r_rbank] : '0;
    assign occ_o    = 2'({1'b0, r_full[0]}) + 2'({1'b0, r_full[1]});
    assign err_o    = r_err;

    // Request qualification: commits and writes only act on a free bank.
    assign w_len_ok     = (wlen_i != '0) && (wlen_i <= LEN_W'(DEPTH));
    assign w_wr_en      = wren_i & wready_o;
    assign w_commit     = wcommit_i & wready_o & w_len_ok;
    assign w_bad_commit = wcommit_i & wready_o & ~w_len_ok;
    assign w_release    = rrelease_i & rvalid_o;

    // Random-access read; out-of-range or uncommitted reads return zero.
    assign w_rd_hit = rvalid_o && (LEN_W'(raddr_i) < rlen_o);
    assign rdata_o  = w_rd_hit ? r_mem[r_rbank][raddr_i] : '0;

    // Next bank state; commit and release always target different banks.
    always_comb begin
        w_full_nxt  = r_full;
        w_wbank_nxt = r_wbank;
        w_rbank_nxt = r_rbank;
        if (w_commit) begin
            w_full_nxt[r_wbank] = 1'b1;
            w_wbank_nxt         = ~r_wbank;
        end
        if (w_release) begin
            w_full_nxt[r_rbank] = 1'b0;
            w_rbank_nxt         = ~r_rbank;
        end
    end

    // Bank flags, pointers, lengths and the illegal-commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= '0;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_len   <= '{default: '0};
            r_err   <= 1'b0;
        end else begin
            r_full  <= w_full_nxt;
            r_wbank <= w_wbank_nxt;
            r_rbank <= w_rbank_nxt;
            r_err   <= w_bad_commit;
            if (w_commit) begin
                r_len[r_wbank] <= wlen_i;
            end
        end
    end

    // Byte-enabled write into the bank currently being filled.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < int'(BE_WIDTH); i++) begin
                if (wbe_i[i]) begin
                    r_mem[r_wbank][waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_aidc_lite_comp_pingpong_buffer.sv
// Self-checking bench for the ping-pong buffer: committed banks are queued on a scoreboard
// and compared word by word as the read side drains them.
module tb_aidc_lite_comp_pingpong_buffer;

    localparam int DW    = 64;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [AW:0]                 len;
        logic [DEPTH-1:0][DW-1:0]    data;
    } bank_t;

    logic            clk;
    logic            rst_n;
    logic            wren_i;
    logic [AW-1:0]   waddr_i;
    logic [DW/8-1:0] wbe_i;
    logic [DW-1:0]   wdata_i;
    logic            wcommit_i;
    logic [AW:0]     wlen_i;
    logic            wready_o;
    logic [AW-1:0]   raddr_i;
    logic [DW-1:0]   rdata_o;
    logic            rvalid_o;
    logic [AW:0]     rlen_o;
    logic            rrelease_i;
    logic [1:0]      occ_o;
    logic            err_o;

    aidc_lite_comp_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wren_i     (wren_i),
        .waddr_i    (waddr_i),
        .wbe_i      (wbe_i),
        .wdata_i    (wdata_i),
        .wcommit_i  (wcommit_i),
        .wlen_i     (wlen_i),
        .wready_o   (wready_o),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .rlen_o     (rlen_o),
        .rrelease_i (rrelease_i),
        .occ_o      (occ_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bank_t       sb_q[$];
    logic [DW-1:0] m_mem [2][DEPTH];
    logic        m_full [2];
    logic        m_wbank;
    logic        m_rbank;
    int          checks;
    int          errors;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wbank   = 1'b0;
        m_rbank   = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        wren_i  = 1'b1;
        waddr_i = a;
        wdata_i = d;
        wbe_i   = be;
        if (!m_full[m_wbank]) begin
            for (int i = 0; i < DW/8; i++) begin
                if (be[i]) m_mem[m_wbank][a][i*8 +: 8] = d[i*8 +: 8];
            end
        end
        tick();
        wren_i = 1'b0;
        wbe_i  = '0;
    endtask

    // One control cycle: optional commit of wlen and/or release of the read bank.
    task automatic do_ctrl(input logic c, input logic [AW:0] len, input logic r);
        bank_t e;
        logic  c_ok;
        logic  r_ok;
        c_ok = c && !m_full[m_wbank] && (len >= 1) && (len <= DEPTH);
        r_ok = r && m_full[m_rbank];
        wcommit_i  = c;
        wlen_i     = len;
        rrelease_i = r;
        if (c_ok) begin
            e.len = len;
            for (int k = 0; k < DEPTH; k++) e.data[k] = m_mem[m_wbank][k];
            sb_q.push_back(e);
            m_full[m_wbank] = 1'b1;
            m_wbank = ~m_wbank;
        end
        if (r_ok) begin
            void'(sb_q.pop_front());
            m_full[m_rbank] = 1'b0;
            m_rbank = ~m_rbank;
        end
        tick();
        wcommit_i  = 1'b0;
        wlen_i     = '0;
        rrelease_i = 1'b0;
    endtask

    // Compare the read port against the oldest committed bank without releasing it.
    task automatic check_front(input string name);
        bank_t       e;
        logic [DW-1:0] exp_d;
        checks++;
        if (rvalid_o !== (sb_q.size() != 0)) begin
            errors++;
            $display("FAIL %s rvalid got %0b exp %0b", name, rvalid_o, sb_q.size() != 0);
        end
        if (sb_q.size() != 0) begin
            e = sb_q[0];
            checks++;
            if (rlen_o !== e.len) begin
                errors++;
                $display("FAIL %s rlen got %0d exp %0d", name, rlen_o, e.len);
            end
            for (int a = 0; a < DEPTH; a++) begin
                raddr_i = AW'(a);
                #1;
                exp_d = (a < int'(e.len)) ? e.data[a] : '0;
                checks++;
                if (rdata_o !== exp_d) begin
                    errors++;
                    $display("FAIL %s rdata[%0d] got %h exp %h", name, a, rdata_o, exp_d);
                end
            end
        end
    endtask

    task automatic check_status(input string name, input logic exp_wr, input logic exp_rv,
                                input logic [1:0] exp_occ, input logic exp_err);
        checks++;
        if (wready_o !== exp_wr || rvalid_o !== exp_rv || occ_o !== exp_occ || err_o !== exp_err) begin
            errors++;
            $display("FAIL %s wready/rvalid/occ/err got %0b/%0b/%0d/%0b exp %0b/%0b/%0d/%0b",
                     name, wready_o, rvalid_o, occ_o, err_o, exp_wr, exp_rv, exp_occ, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_status("reset_during", 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_status("reset_idle", 1'b1, 1'b0, 2'd0, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            raddr_i = AW'(a);
            #1;
            checks++;
            if (rdata_o !== '0 || rlen_o !== '0) begin
                errors++;
                $display("FAIL reset_rdata[%0d] got %h len %0d exp 0", a, rdata_o, rlen_o);
            end
        end
    endtask

    task automatic test_fill_read();
        logic [DW-1:0] base;
        base = 64'h1111_1111_1111_1111;
        for (int k = 0; k < DEPTH; k++) do_write(AW'(k), base + DW'(k), 8'hFF);
        do_ctrl(1'b1, 4'd8, 1'b0);
        check_status("fill_commit", 1'b1, 1'b1, 2'd1, 1'b0);
        raddr_i = 3'd5;
        #1;
        checks++;
        if (rdata_o !== 64'h1111_1111_1111_1116 || rlen_o !== 4'd8) begin
            errors++;
            $display("FAIL fill_raddr5 got %h len %0d exp 1111111111111116 len 8", rdata_o, rlen_o);
        end
        check_front("fill_drain");
        do_ctrl(1'b0, '0, 1'b1);
        check_status("fill_released", 1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_byte_enable();
        do_write(3'd0, 64'hA0A0_A0A0_0000_0000, 8'hFF);
        do_write(3'd1, 64'hB1B1_0000_C2C2_0000, 8'hFF);
        do_write(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_write(3'd2, 64'h0, 8'h0F);
        do_ctrl(1'b1, 4'd3, 1'b0);
        raddr_i = 3'd2;
        #1;
        checks++;
        if (rdata_o !== 64'hFFFF_FFFF_0000_0000) begin
            errors++;
            $display("FAIL be_raddr2 got %h exp ffffffff00000000", rdata_o);
        end
        raddr_i = 3'd3;
        #1;
        checks++;
        if (rdata_o !== '0) begin
            errors++;
            $display("FAIL be_raddr3 got %h exp 0", rdata_o);
        end
        check_front("be_drain");
        do_ctrl(1'b0, '0, 1'b1);
    endtask

    task automatic test_both_full();
        for (int k = 0; k < 4; k++) do_write(AW'(k), 64'h2222_0000_0000_0000 + DW'(k), 8'hFF);
        do_ctrl(1'b1, 4'd4, 1'b0);
        for (int k = 0; k < 6; k++) do_write(AW'(k), 64'h3333_0000_0000_0000 + DW'(k * 3), 8'hFF);
        do_ctrl(1'b1, 4'd6, 1'b0);
        check_status("both_full", 1'b0, 1'b1, 2'd2, 1'b0);
        do_write(3'd0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        do_ctrl(1'b1, 4'd2, 1'b0);
        check_status("full_ignored", 1'b0, 1'b1, 2'd2, 1'b0);
        check_front("full_first");
        do_ctrl(1'b0, '0, 1'b1);
        check_status("full_release", 1'b1, 1'b1, 2'd1, 1'b0);
        check_front("full_second");
        do_ctrl(1'b0, '0, 1'b1);
        check_status("full_empty", 1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_commit_release();
        for (int k = 0; k < 2; k++) do_write(AW'(k), 64'h4444_0000_0000_0000 + DW'(k), 8'hFF);
        do_ctrl(1'b1, 4'd2, 1'b0);
        for (int k = 0; k < 4; k++) do_write(AW'(k), 64'h5555_0000_0000_0000 + DW'(k * 7), 8'hFF);
        check_front("cr_bank0");
        do_ctrl(1'b1, 4'd4, 1'b1);
        check_status("cr_same_cycle", 1'b1, 1'b1, 2'd1, 1'b0);
        checks++;
        if (rlen_o !== 4'd4) begin
            errors++;
            $display("FAIL cr_rlen got %0d exp 4", rlen_o);
        end
        check_front("cr_bank1");
        do_ctrl(1'b0, '0, 1'b1);
    endtask

    task automatic test_illegal();
        do_write(3'd0, 64'h6666_7777_8888_9999, 8'hFF);
        do_ctrl(1'b1, 4'd0, 1'b0);
        check_status("illegal_len0", 1'b1, 1'b0, 2'd0, 1'b1);
        tick();
        check_status("illegal_len0_clear", 1'b1, 1'b0, 2'd0, 1'b0);
        do_ctrl(1'b1, 4'd9, 1'b0);
        check_status("illegal_len9", 1'b1, 1'b0, 2'd0, 1'b1);
        tick();
        check_status("illegal_len9_clear", 1'b1, 1'b0, 2'd0, 1'b0);
        do_ctrl(1'b1, 4'd1, 1'b0);
        check_status("legal_after", 1'b1, 1'b1, 2'd1, 1'b0);
        check_front("illegal_drain");
        do_ctrl(1'b0, '0, 1'b1);
        do_ctrl(1'b0, '0, 1'b1);
        check_status("release_empty", 1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_write(3'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
        do_ctrl(1'b1, 4'd1, 1'b0);
        do_write(3'd0, 64'hFEDC_BA98_7654_3210, 8'hFF);
        do_ctrl(1'b1, 4'd1, 1'b0);
        check_status("mid_full", 1'b0, 1'b1, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_status("mid_reset", 1'b1, 1'b0, 2'd0, 1'b0);
        raddr_i = 3'd0;
        #1;
        checks++;
        if (rdata_o !== '0 || rlen_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_rdata got %h len %0d exp 0", rdata_o, rlen_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        check_status("mid_after", 1'b1, 1'b0, 2'd0, 1'b0);
        do_write(3'd0, 64'hCAFE_F00D_0000_0001, 8'hFF);
        do_ctrl(1'b1, 4'd1, 1'b0);
        check_front("mid_restart");
        do_ctrl(1'b0, '0, 1'b1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        wren_i     = 1'b0;
        waddr_i    = '0;
        wbe_i      = '0;
        wdata_i    = '0;
        wcommit_i  = 1'b0;
        wlen_i     = '0;
        raddr_i    = '0;
        rrelease_i = 1'b0;
        test_reset();
        test_fill_read();
        test_byte_enable();
        test_both_full();
        test_commit_release();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
